// File: rtl/random_pkg.sv
// Shared FSM state type and default LFSR constants for the random-source blocks.
package random_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      HOLD
   } rng_state_e;

   // Right-shift Galois masks giving maximal-length sequences
   localparam logic [3:0]  TAPS_W4      = 4'h9;
   localparam logic [7:0]  TAPS_W8      = 8'hB8;
   localparam logic [15:0] TAPS_W16     = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// Right-shift Galois LFSR with runtime seed load and an all-zero lockup guard.
module lfsr_core
   import random_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
   parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed,
   output logic [WIDTH-1:0] o_state
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (i_seed_load) begin
         state_d = (i_seed == '0) ? SEED : i_seed;
      end else if (state_q == '0) begin
         state_d = SEED;
      end else begin
         state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign o_state = state_q;

endmodule

// File: rtl/lfsr_range_gen.sv
// Uniform 0..RANGE-1 draws from an LFSR by rejection sampling with bounded retries.
// Optional macro LFSR_RANGE_NO_REPEAT_EN forbids consecutive equal accepted outputs.
module lfsr_range_gen
   import random_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
   parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
   parameter int unsigned      RANGE     = 9,
   parameter int unsigned      MAX_TRIES = 8,
   localparam int unsigned     OUT_W     = $clog2(RANGE)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed,
   input  logic             i_req,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_value,
   output logic             o_fallback,
   output logic             o_busy
);

   localparam int unsigned      CNT_W   = $clog2(MAX_TRIES + 1);
   localparam logic [OUT_W:0]   RANGE_X = (OUT_W + 1)'(RANGE);
   localparam logic [CNT_W:0]   TRIES_X = (CNT_W + 1)'(MAX_TRIES);

   logic [WIDTH-1:0] lfsr_state;
   logic [OUT_W-1:0] cand;
   logic [OUT_W:0]   diff;
   logic [OUT_W-1:0] base;
   logic [OUT_W-1:0] fb_value;
   logic             in_range;
   logic             accept;
   logic             handshake;
   logic [CNT_W:0]   try_next;
   logic             unused_bits;

   rng_state_e       state_q, state_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] value_q, value_d;
   logic             fallback_q, fallback_d;
   logic [CNT_W-1:0] try_cnt_q, try_cnt_d;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_seed_load (i_seed_load),
      .i_seed      (i_seed),
      .o_state     (lfsr_state)
   );

   assign cand        = lfsr_state[OUT_W-1:0];
   assign in_range    = {1'b0, cand} < RANGE_X;
   assign diff        = {1'b0, cand} - RANGE_X;
   assign base        = in_range ? cand : diff[OUT_W-1:0];
   assign handshake   = (state_q == HOLD) && valid_q && i_ready;
   assign try_next    = {1'b0, try_cnt_q} + (CNT_W + 1)'(1);
   assign unused_bits = ^{lfsr_state[WIDTH-1:OUT_W], diff[OUT_W]};

`ifdef LFSR_RANGE_NO_REPEAT_EN
   logic [OUT_W-1:0] last_q;
   logic             has_last_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_q     <= '0;
         has_last_q <= 1'b0;
      end else if (handshake) begin
         last_q     <= value_q;
         has_last_q <= 1'b1;
      end
   end

   assign accept   = in_range && !(has_last_q && (cand == last_q));
   // Fallback steps past the previous output, wrapping at RANGE
   assign fb_value = (base != last_q) ? base :
                     (({1'b0, base} == RANGE_X - (OUT_W + 1)'(1)) ? '0 : base + OUT_W'(1));
`else
   assign accept   = in_range;
   assign fb_value = base;
`endif

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      value_d    = value_q;
      fallback_d = fallback_q;
      try_cnt_d  = try_cnt_q;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               if (accept) begin
                  value_d    = cand;
                  valid_d    = 1'b1;
                  fallback_d = 1'b0;
                  state_d    = HOLD;
               end else if (MAX_TRIES == 1) begin
                  value_d    = fb_value;
                  valid_d    = 1'b1;
                  fallback_d = 1'b1;
                  state_d    = HOLD;
               end else begin
                  try_cnt_d  = CNT_W'(1);
                  state_d    = DRAW;
               end
            end
         end
         DRAW: begin
            if (accept) begin
               value_d    = cand;
               valid_d    = 1'b1;
               fallback_d = 1'b0;
               try_cnt_d  = '0;
               state_d    = HOLD;
            end else if (try_next == TRIES_X) begin
               value_d    = fb_value;
               valid_d    = 1'b1;
               fallback_d = 1'b1;
               try_cnt_d  = '0;
               state_d    = HOLD;
            end else begin
               try_cnt_d  = try_next[CNT_W-1:0];
            end
         end
         HOLD: begin
            if (handshake) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         value_q    <= '0;
         fallback_q <= 1'b0;
         try_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         value_q    <= value_d;
         fallback_q <= fallback_d;
         try_cnt_q  <= try_cnt_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_value    = value_q;
   assign o_fallback = fallback_q;
   assign o_busy     = (state_q == DRAW);

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Self-checking bench for lfsr_range_gen: directed vector table, async-reset check,
// randomized draws against a transaction-level model, and no-repeat statistics.
module tb_lfsr_range_gen;

   localparam logic [15:0] SEED  = 16'hACE1;
   localparam logic [15:0] TAPS  = 16'hB400;
   localparam int          RANGE = 9;
   localparam int          MAXT  = 8;
`ifdef LFSR_RANGE_NO_REPEAT_EN
   localparam bit NOREP = 1'b1;
`else
   localparam bit NOREP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, ld, req, rdy;
   logic [15:0] seed;
   logic        v, fb, busy, v1, fb1, busy1;
   logic [3:0]  val, val1;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   lfsr_range_gen dut (
      .i_clk(clk), .i_rst(rst), .i_seed_load(ld), .i_seed(seed), .i_req(req),
      .o_valid(v), .i_ready(rdy), .o_value(val), .o_fallback(fb), .o_busy(busy)
   );

   lfsr_range_gen #(.MAX_TRIES(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_seed_load(ld), .i_seed(seed), .i_req(req),
      .o_valid(v1), .i_ready(rdy), .o_value(val1), .o_fallback(fb1), .o_busy(busy1)
   );

   typedef struct {
      logic        rst, ld;
      logic [15:0] seed;
      logic        req, rdy;
      logic [15:0] lfsr;
      logic        v;
      logic [3:0]  val;
      logic        fb, busy;
      logic        v1;
      logic [3:0]  val1;
      logic        fb1;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(logic r, logic l, logic [15:0] s, logic q, logic y, logic [15:0] lf,
                               logic ev, logic [3:0] eval, logic efb, logic eb,
                               logic ev1, logic [3:0] eval1, logic efb1);
      vec_t t;
      t.rst = r; t.ld = l; t.seed = s; t.req = q; t.rdy = y; t.lfsr = lf;
      t.v = ev; t.val = eval; t.fb = efb; t.busy = eb;
      t.v1 = ev1; t.val1 = eval1; t.fb1 = efb1;
      return t;
   endfunction

   function automatic logic [15:0] nxt(input logic [15:0] s);
      if (s == 16'h0) return SEED;
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   // Outcome of one draw starting from LFSR state s0: value, fallback flag, clocks to valid
   function automatic void predict(input logic [15:0] s0, input int maxt, input logic [3:0] last,
                                   input bit hl, output logic [3:0] pv, output bit pfb, output int lat);
      logic [15:0] s;
      int c, b;
      s = s0;
      pv = 4'h0; pfb = 1'b0; lat = 0;
      for (int k = 0; k < maxt; k++) begin
         c = int'(s[3:0]);
         if (c < RANGE && !(NOREP && hl && c == int'(last))) begin
            pv = 4'(c); pfb = 1'b0; lat = k + 1;
            return;
         end
         if (k == maxt - 1) begin
            b = (c >= RANGE) ? c - RANGE : c;
            if (NOREP && b == int'(last)) b = (b + 1) % RANGE;
            pv = 4'(b); pfb = 1'b1; lat = maxt;
            return;
         end
         s = nxt(s);
      end
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic step();
      m_lfsr = ld ? ((seed == 16'h0) ? SEED : seed) : nxt(m_lfsr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e0, e1, last0, last1;
      bit         f0, f1, hl0, hl1;
      int         lat0, lat1, cyc;
      logic [15:0] s;

      rst = 1'b1; ld = 1'b0; seed = 16'h0; req = 1'b0; rdy = 1'b0;
      m_lfsr = SEED;

      //          rst ld seed      req rdy lfsr      v val fb busy v1 val1 fb1
      tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 16'hACE1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 16'h0000, 1, 0, 16'hE270, 1, 1, 0, 0, 1, 1, 0);
      tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 16'h7138, 0, 1, 0, 0, 0, 1, 0);
      tbl[3]  = mk(0, 1, 16'h000C, 0, 0, 16'h000C, 0, 1, 0, 0, 0, 1, 0);
      tbl[4]  = mk(0, 0, 16'h0000, 1, 1, 16'h0006, 0, 1, 0, 1, 1, 3, 1);
      tbl[5]  = mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 6, 0, 0, 0, 3, 1);
      tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 16'hB401, 1, 6, 0, 0, 0, 3, 1);
      tbl[7]  = mk(0, 1, 16'h1234, 1, 0, 16'h1234, 1, 6, 0, 0, 1, 1, 0);
      tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h091A, 1, 6, 0, 0, 1, 1, 0);
      tbl[9]  = mk(0, 0, 16'h0000, 1, 0, 16'h048D, 1, 6, 0, 0, 1, 1, 0);
      tbl[10] = mk(0, 1, 16'h0000, 0, 0, 16'hACE1, 1, 6, 0, 0, 1, 1, 0);
      tbl[11] = mk(0, 0, 16'h0000, 1, 0, 16'hE270, 1, 6, 0, 0, 1, 1, 0);
      tbl[12] = mk(0, 0, 16'h0000, 1, 1, 16'h7138, 0, 6, 0, 0, 0, 1, 0);
      tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h389C, 0, 6, 0, 0, 0, 1, 0);
      tbl[14] = mk(1, 0, 16'h0000, 0, 0, 16'hACE1, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 0, 16'h0000, 0, 0, 16'hE270, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 16'h0000, 0, 0, 16'h7138, 0, 0, 0, 0, 0, 0, 0);
      tbl[17] = mk(0, 0, 16'h0000, 0, 0, 16'h389C, 0, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 16'h0000, 0, 0, 16'h1C4E, 0, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0E27, 0, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(0, 0, 16'h0000, 0, 0, 16'hB313, 0, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 1, 16'h000C, 0, 0, 16'h000C, 0, 0, 0, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 16'h0000, 1, 0, 16'h0006, 0, 0, 0, 1, 1, 3, 1);

      for (int i = 0; i < 23; i++) begin
         rst = tbl[i].rst; ld = tbl[i].ld; seed = tbl[i].seed;
         req = tbl[i].req; rdy = tbl[i].rdy;
         step();
         chk("lfsr", i, dut.lfsr_state, tbl[i].lfsr);
         chk("valid", i, v, tbl[i].v);
         chk("value", i, val, tbl[i].val);
         chk("fallback", i, fb, tbl[i].fb);
         chk("busy", i, busy, tbl[i].busy);
         chk("valid_mt1", i, v1, tbl[i].v1);
         chk("value_mt1", i, val1, tbl[i].val1);
         chk("fallback_mt1", i, fb1, tbl[i].fb1);
      end

      // Asynchronous reset while dut is in DRAW and dut1 in HOLD
      ld = 1'b0; req = 1'b0; rdy = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_valid", 0, v, 0);
      chk("arst_busy", 0, busy, 0);
      chk("arst_value", 0, val, 0);
      chk("arst_lfsr", 0, dut.lfsr_state, 16'hACE1);
      chk("arst_valid_mt1", 0, v1, 0);
      chk("arst_fallback_mt1", 0, fb1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_lfsr = SEED;
      last0 = 4'h0; last1 = 4'h0; hl0 = 1'b0; hl1 = 1'b0;

      // Randomized draws against the transaction-level model
      for (int t = 0; t < 250; t++) begin
         req = 1'b0; rdy = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            ld = 1'b1;
            seed = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            step();
            ld = 1'b0;
         end
         for (int k = $urandom_range(0, 2); k > 0; k--) step();
         s = m_lfsr;
         predict(s, MAXT, last0, hl0, e0, f0, lat0);
         predict(s, 1, last1, hl1, e1, f1, lat1);
         req = 1'b1;
         step();
         cyc = 1;
         while (!v && cyc < MAXT + 3) begin
            req = 1'($urandom);
            step();
            cyc++;
         end
         chk("rnd_valid", t, v, 1);
         chk("rnd_latency", t, cyc, lat0);
         chk("rnd_value", t, val, e0);
         chk("rnd_fallback", t, fb, f0);
         chk("rnd_busy", t, busy, 0);
         chk("rnd_valid_mt1", t, v1, 1);
         chk("rnd_value_mt1", t, val1, e1);
         chk("rnd_fallback_mt1", t, fb1, f1);
         chk("rnd_busy_mt1", t, busy1, 0);
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            req = 1'($urandom);
            ld = ($urandom_range(0, 2) == 0);
            seed = 16'($urandom);
            step();
            ld = 1'b0;
            chk("hold_valid", t, v, 1);
            chk("hold_value", t, val, e0);
            chk("hold_value_mt1", t, val1, e1);
         end
         rdy = 1'b1;
         req = 1'($urandom);
         step();
         chk("hs_valid", t, v, 0);
         chk("hs_valid_mt1", t, v1, 0);
         last0 = e0; hl0 = 1'b1;
         last1 = e1; hl1 = 1'b1;
      end
      req = 1'b0; rdy = 1'b0;
      step();

`ifdef LFSR_RANGE_NO_REPEAT_EN
      begin
         int cnt[RANGE];
         int draws, budget;
         logic [3:0] prev;
         bit have_prev;
         for (int i = 0; i < RANGE; i++) cnt[i] = 0;
         draws = 0; budget = 0; have_prev = 1'b0; prev = 4'h0;
         req = 1'b1; rdy = 1'b1;
         while (draws < 10000 && budget < 60000) begin
            step();
            budget++;
            if (v) begin
               n_vec++;
               if (int'(val) >= RANGE || (have_prev && val == prev)) begin
                  n_err++;
                  $display("FAIL norep_draw[%0d]: got %0d after %0d, expected <%0d and different", draws, val, prev, RANGE);
               end
               if (int'(val) < RANGE) cnt[int'(val)]++;
               prev = val; have_prev = 1'b1;
               draws++;
            end
         end
         req = 1'b0; rdy = 1'b0;
         chk("norep_draw_count", 0, draws, 10000);
         for (int i = 0; i < RANGE; i++) begin
            n_vec++;
            if (cnt[i] < 1000 || cnt[i] > 1222) begin
               n_err++;
               $display("FAIL norep_hist[%0d]: got %0d, expected 1000..1222", i, cnt[i]);
            end
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
